// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the seven-segment display scheduler:
// owner states, one-hot grant codes and the blank digit code.
package display_scheduler_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned DIGITS   = 8;
  localparam int unsigned CODE_W   = DIGIT_W * DIGITS;
  localparam int unsigned GRANT_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_BG = 2'd1,
    SHOW_ST = 2'd2,
    ALERT   = 2'd3
  } state_e;

  localparam logic [GRANT_W-1:0] GRANT_NONE  = 3'b000;
  localparam logic [GRANT_W-1:0] GRANT_BG    = 3'b001;
  localparam logic [GRANT_W-1:0] GRANT_ST    = 3'b010;
  localparam logic [GRANT_W-1:0] GRANT_ALERT = 3'b100;

  localparam logic [DIGIT_W-1:0] DIGIT_NULL = 4'h0;
  localparam logic [CODE_W-1:0]  CODE_BLANK = {DIGITS{DIGIT_NULL}};

  // One-hot owner code presented on the grant output for a given state.
  function automatic logic [GRANT_W-1:0] grant_of(input state_e s);
    logic [GRANT_W-1:0] g;
    g = GRANT_NONE;
    case (s)
      SHOW_BG: g = GRANT_BG;
      SHOW_ST: g = GRANT_ST;
      ALERT:   g = GRANT_ALERT;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/display_scheduler_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, asserted while the
// internal count sits at TICK_DIV-1 (registered one cycle ahead, needs TICK_DIV >= 2).
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_q == CW'(TICK_DIV - 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the 8-digit display driver between alert, status and background
// requesters with status minimum hold, alert timeout and blink timing.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned MIN_HOLD    = 500,
  parameter int unsigned ALERT_TICKS = 2000,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alert_req,
  input  logic [31:0] alert_code,
  input  logic        stat_req,
  input  logic [31:0] stat_code,
  input  logic        stat_blink,
  input  logic        bg_req,
  input  logic [31:0] bg_code,
  input  logic        bg_blink,
  output logic        en,
  output logic [3:0]  sign7,
  output logic [3:0]  sign6,
  output logic [3:0]  sign5,
  output logic [3:0]  sign4,
  output logic [3:0]  sign3,
  output logic [3:0]  sign2,
  output logic [3:0]  sign1,
  output logic [3:0]  sign0,
  output logic [2:0]  grant,
  output logic        alert_done
);

  localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] ALERT_MAX  = CNT_W'(ALERT_TICKS);
  localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0]    alert_cnt_q, alert_cnt_d;
  logic [CNT_W-1:0]    blink_q, blink_d;
  logic                en_q, en_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic                alert_done_q, alert_done_d;
  logic                restart, changed, blink_on;

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    hold_d       = hold_q;
    alert_cnt_d  = alert_cnt_q;
    blink_d      = blink_q;
    en_d         = en_q;
    alert_done_d = 1'b0;
    restart      = 1'b0;
    changed      = 1'b0;
    blink_on     = 1'b0;

    // Owner selection; a new alert pulse overrides everything, even its own expiry.
    if (alert_req) begin
      state_d = ALERT;
      restart = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (stat_req)    state_d = SHOW_ST;
          else if (bg_req) state_d = SHOW_BG;
        end
        SHOW_BG: begin
          if (stat_req)     state_d = SHOW_ST;
          else if (!bg_req) state_d = IDLE;
        end
        SHOW_ST: begin
          if (!stat_req && (hold_q >= HOLD_MAX)) state_d = bg_req ? SHOW_BG : IDLE;
        end
        ALERT: begin
          if (tick && (alert_cnt_q >= ALERT_LAST)) begin
            alert_done_d = 1'b1;
            state_d      = stat_req ? SHOW_ST : (bg_req ? SHOW_BG : IDLE);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    changed = restart || (state_d != state_q);

    if (changed) begin
      hold_d      = '0;
      alert_cnt_d = '0;
    end else if (tick) begin
      if ((state_q == SHOW_ST) && (hold_q < HOLD_MAX))     hold_d      = hold_q + CNT_W'(1);
      if ((state_q == ALERT) && (alert_cnt_q < ALERT_MAX)) alert_cnt_d = alert_cnt_q + CNT_W'(1);
    end

    // Status freezes its last code while only the hold keeps it on screen.
    case (state_d)
      IDLE:    code_d = CODE_BLANK;
      SHOW_BG: if (bg_req)   code_d = bg_code;
      SHOW_ST: if (stat_req) code_d = stat_code;
      ALERT:   if (restart)  code_d = alert_code;
      default: code_d = CODE_BLANK;
    endcase

    blink_on = (state_d == ALERT) ||
               ((state_d == SHOW_ST) && stat_blink) ||
               ((state_d == SHOW_BG) && bg_blink);

    if (state_d == IDLE) begin
      en_d    = 1'b0;
      blink_d = '0;
    end else if (changed || !blink_on) begin
      en_d    = 1'b1;
      blink_d = '0;
    end else if (tick) begin
      if (blink_q >= BLINK_LAST) begin
        en_d    = !en_q;
        blink_d = '0;
      end else begin
        blink_d = blink_q + CNT_W'(1);
      end
    end

    grant_d = grant_of(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= CODE_BLANK;
      hold_q       <= '0;
      alert_cnt_q  <= '0;
      blink_q      <= '0;
      en_q         <= 1'b0;
      grant_q      <= GRANT_NONE;
      alert_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      hold_q       <= hold_d;
      alert_cnt_q  <= alert_cnt_d;
      blink_q      <= blink_d;
      en_q         <= en_d;
      grant_q      <= grant_d;
      alert_done_q <= alert_done_d;
    end
  end

  assign en         = en_q;
  assign grant      = grant_q;
  assign alert_done = alert_done_q;
  assign sign7      = code_q[31:28];
  assign sign6      = code_q[27:24];
  assign sign5      = code_q[23:20];
  assign sign4      = code_q[19:16];
  assign sign3      = code_q[15:12];
  assign sign2      = code_q[11:8];
  assign sign1      = code_q[7:4];
  assign sign0      = code_q[3:0];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with TICK_DIV=4, MIN_HOLD=3,
// ALERT_TICKS=5, BLINK_TICKS=2.
module tb_display_scheduler;

  localparam int TDIV = 4;
  localparam int HOLD = 3;
  localparam int ATCK = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        alert_req;
  logic [31:0] alert_code;
  logic        stat_req;
  logic [31:0] stat_code;
  logic        stat_blink;
  logic        bg_req;
  logic [31:0] bg_code;
  logic        bg_blink;
  logic        en;
  logic [3:0]  sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0;
  logic [2:0]  grant;
  logic        alert_done;
  logic [31:0] shown;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  assign shown = {sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0};

  display_scheduler #(
    .TICK_DIV(4), .MIN_HOLD(3), .ALERT_TICKS(5), .BLINK_TICKS(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .alert_req(alert_req), .alert_code(alert_code),
    .stat_req(stat_req), .stat_code(stat_code), .stat_blink(stat_blink),
    .bg_req(bg_req), .bg_code(bg_code), .bg_blink(bg_blink),
    .en(en),
    .sign7(sign7), .sign6(sign6), .sign5(sign5), .sign4(sign4),
    .sign3(sign3), .sign2(sign2), .sign1(sign1), .sign0(sign0),
    .grant(grant), .alert_done(alert_done)
  );

  typedef struct {
    logic        st_req;
    logic [31:0] st_code;
    logic        b_req;
    logic [31:0] b_code;
    logic [2:0]  x_grant;
    logic        x_en;
    logic [31:0] x_code;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // After a reset release, the tick is consumed at every edge whose index is a multiple of TDIV.
  task automatic do_reset();
    rst = 1'b1;
    alert_req = 1'b0; alert_code = '0;
    stat_req = 1'b0; stat_code = '0; stat_blink = 1'b0;
    bg_req = 1'b0; bg_code = '0; bg_blink = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  function automatic int ticks_since(input int from, input int upto);
    return upto / TDIV - from / TDIV;
  endfunction

  function automatic int nth_tick(input int from, input int n);
    return (from / TDIV + n) * TDIV;
  endfunction

  function automatic logic blink_en(input int entry, input int now);
    return ((ticks_since(entry, now) / 2) % 2) == 0;
  endfunction

  task automatic watch_alert(input int entry, input int last, input logic [31:0] code);
    while (cyc < last) begin
      step();
      check("alert_grant", 32'(grant), 32'(3'b100));
      check("alert_en", 32'(en), 32'(blink_en(entry, cyc)));
      check("alert_done_quiet", 32'(alert_done), 32'(1'b0));
      check("alert_code", shown, code);
    end
  endtask

  int st_entry;
  int entry;
  int release_cyc;

  initial begin
    vecs[0] = '{1'b0, 32'h0,        1'b0, 32'h0,        3'b000, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h01234567, 3'b001, 1'b1, 32'h01234567};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 32'h76543210, 3'b001, 1'b1, 32'h76543210};
    vecs[3] = '{1'b0, 32'h0,        1'b0, 32'h76543210, 3'b000, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 32'hA5A5A5A5, 3'b001, 1'b1, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 32'h89898989, 1'b1, 32'hA5A5A5A5, 3'b010, 1'b1, 32'h89898989};
    vecs[6] = '{1'b1, 32'h12121212, 1'b1, 32'hA5A5A5A5, 3'b010, 1'b1, 32'h12121212};

    do_reset();
    check("rst_en", 32'(en), 32'(1'b0));
    check("rst_grant", 32'(grant), 32'(3'b000));
    check("rst_signs", shown, 32'h0);
    check("rst_done", 32'(alert_done), 32'(1'b0));

    st_entry = 0;
    for (int i = 0; i < 7; i++) begin
      stat_req = vecs[i].st_req;
      stat_code = vecs[i].st_code;
      bg_req = vecs[i].b_req;
      bg_code = vecs[i].b_code;
      step();
      if (i == 5) st_entry = cyc;
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].x_grant));
      check($sformatf("vec%0d_en", i), 32'(en), 32'(vecs[i].x_en));
      check($sformatf("vec%0d_signs", i), shown, vecs[i].x_code);
    end

    // Status hold: release one tick in, stays until the third tick after entry.
    while (ticks_since(st_entry, cyc) < 1) step();
    stat_req = 1'b0;
    stat_code = 32'h00000000;
    release_cyc = nth_tick(st_entry, HOLD) + 1;
    while (cyc < release_cyc - 1) begin
      step();
      check("hold_grant", 32'(grant), 32'(3'b010));
      check("hold_frozen", shown, 32'h12121212);
    end
    step();
    check("hold_release_grant", 32'(grant), 32'(3'b001));
    check("hold_release_signs", shown, 32'hA5A5A5A5);

    // Alert timeout returning to status.
    stat_req = 1'b1; stat_code = 32'h34343434;
    step();
    check("st_again_grant", 32'(grant), 32'(3'b010));
    alert_req = 1'b1; alert_code = 32'hEEEEEEEE;
    step();
    alert_req = 1'b0;
    entry = cyc;
    check("alert_entry_grant", 32'(grant), 32'(3'b100));
    check("alert_entry_en", 32'(en), 32'(1'b1));
    watch_alert(entry, nth_tick(entry, ATCK) - 1, 32'hEEEEEEEE);
    step();
    check("expire_done", 32'(alert_done), 32'(1'b1));
    check("expire_grant", 32'(grant), 32'(3'b010));
    check("expire_signs", shown, 32'h34343434);
    check("expire_en", 32'(en), 32'(1'b1));
    step();
    check("expire_done_once", 32'(alert_done), 32'(1'b0));

    // Restart at the fourth tick; only the second alert times out.
    alert_req = 1'b1; alert_code = 32'hEEEEEEEE;
    step();
    alert_req = 1'b0;
    entry = cyc;
    watch_alert(entry, nth_tick(entry, 4) - 1, 32'hEEEEEEEE);
    alert_req = 1'b1; alert_code = 32'hFFFFFFFF;
    step();
    alert_req = 1'b0;
    entry = cyc;
    check("restart_signs", shown, 32'hFFFFFFFF);
    check("restart_done", 32'(alert_done), 32'(1'b0));
    check("restart_en", 32'(en), 32'(1'b1));
    watch_alert(entry, nth_tick(entry, ATCK) - 1, 32'hFFFFFFFF);
    step();
    check("restart_expire_done", 32'(alert_done), 32'(1'b1));
    check("restart_expire_grant", 32'(grant), 32'(3'b010));
    step();

    // Restart landing exactly on the expiry edge suppresses alert_done.
    alert_req = 1'b1; alert_code = 32'hEEEEEEEE;
    step();
    alert_req = 1'b0;
    entry = cyc;
    watch_alert(entry, nth_tick(entry, ATCK) - 1, 32'hEEEEEEEE);
    alert_req = 1'b1; alert_code = 32'hFFFFFFFF;
    step();
    alert_req = 1'b0;
    check("coincide_done", 32'(alert_done), 32'(1'b0));
    check("coincide_grant", 32'(grant), 32'(3'b100));
    check("coincide_signs", shown, 32'hFFFFFFFF);
    step();
    check("coincide_done_next", 32'(alert_done), 32'(1'b0));

    // Reset while the alert is active.
    rst = 1'b1; stat_req = 1'b0; bg_req = 1'b0;
    step();
    check("midrst_en", 32'(en), 32'(1'b0));
    check("midrst_grant", 32'(grant), 32'(3'b000));
    check("midrst_signs", shown, 32'h0);
    check("midrst_done", 32'(alert_done), 32'(1'b0));
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      check("post_rst_done", 32'(alert_done), 32'(1'b0));
      check("post_rst_grant", 32'(grant), 32'(3'b000));
    end

    // Background blink, then drop blink during the off phase.
    do_reset();
    bg_req = 1'b1; bg_code = 32'h01234567; bg_blink = 1'b1;
    step();
    entry = cyc;
    check("blink_grant", 32'(grant), 32'(3'b001));
    check("blink_entry_en", 32'(en), 32'(1'b1));
    while (cyc < 26) begin
      step();
      check("blink_en", 32'(en), 32'(blink_en(entry, cyc)));
    end
    check("blink_offphase", 32'(en), 32'(1'b0));
    bg_blink = 1'b0;
    step();
    check("blink_drop_en", 32'(en), 32'(1'b1));
    check("blink_drop_grant", 32'(grant), 32'(3'b001));
    for (int i = 0; i < 8; i++) begin
      step();
      check("steady_en", 32'(en), 32'(1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

endmodule
